// File: rtl/tx_pkt_arbiter_pkg.sv
// Shared types and defaults for the two-source TX packet arbiter.
`timescale 1ns/1ps
package tx_pkt_arbiter_pkg;

    typedef enum logic {
        TXARB_IDLE = 1'b0,
        TXARB_BUSY = 1'b1
    } arb_state_e;

    // Jumbo frame of 9600 bytes at 8 bytes per beat.
    localparam int TXARB_MAX_BEATS = 1200;
    localparam int TXARB_CNT_W     = 32;

    typedef struct packed {
        logic        val;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic [63:0] data;
    } beat_t;

endpackage

// File: rtl/tx_pkt_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the non-last owner.
`timescale 1ns/1ps
module tx_pkt_arbiter_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       any,
    output logic       winner
);

    assign any    = |req;
    assign winner = (&req) ? ~last : req[1];

endmodule

// File: rtl/tx_pkt_arbiter.sv
// Whole-packet round-robin scheduler of two beat sources onto the tx_enqueue client port.
// Handshake: a source may assert val only while its gnt is high; granted beats are never stalled.
`timescale 1ns/1ps
module tx_pkt_arbiter
    import tx_pkt_arbiter_pkg::*;
#(
    parameter int MAX_BEATS = TXARB_MAX_BEATS,
    parameter int CNT_W     = TXARB_CNT_W
) (
    input  logic             clk_156m25,
    input  logic             reset_156m25_n,
    input  logic             src0_req,
    input  logic             src1_req,
    output logic             src0_gnt,
    output logic             src1_gnt,
    input  logic [63:0]      src0_data,
    input  logic             src0_val,
    input  logic             src0_sop,
    input  logic             src0_eop,
    input  logic [2:0]       src0_mod,
    input  logic [63:0]      src1_data,
    input  logic             src1_val,
    input  logic             src1_sop,
    input  logic             src1_eop,
    input  logic [2:0]       src1_mod,
    input  logic             pkt_tx_full,
    output logic [63:0]      pkt_tx_data,
    output logic             pkt_tx_val,
    output logic             pkt_tx_sop,
    output logic             pkt_tx_eop,
    output logic [2:0]       pkt_tx_mod,
    output logic             status_arb_proto_err_tog,
    output logic             status_arb_oversize_tog,
    output logic [CNT_W-1:0] stat_src0_pkts,
    output logic [CNT_W-1:0] stat_src1_pkts,
    output logic             dbg_state
);

    localparam int BC_W = $clog2(MAX_BEATS + 1);
    localparam logic [BC_W-1:0] MAX_CNT  = BC_W'(MAX_BEATS);
    localparam logic [BC_W-1:0] LAST_CNT = BC_W'(MAX_BEATS - 1);

    arb_state_e      state, state_nxt;
    logic            owner, owner_nxt;
    logic            last_owner, last_owner_nxt;
    logic [1:0]      gnt, gnt_nxt;
    logic            first_beat;
    logic [BC_W-1:0] beat_cnt;
    beat_t           src_beat [2];
    beat_t           own_beat;
    logic            pick_any, pick_winner;
    logic            owner_fire, owner_eop;
    logic            stray_err, sop_err;

    assign src_beat[0] = '{val: src0_val, sop: src0_sop, eop: src0_eop, mod: src0_mod, data: src0_data};
    assign src_beat[1] = '{val: src1_val, sop: src1_sop, eop: src1_eop, mod: src1_mod, data: src1_data};
    assign own_beat    = src_beat[owner];

    assign owner_fire = (state == TXARB_BUSY) && gnt[owner] && own_beat.val;
    assign owner_eop  = owner_fire && own_beat.eop;

    tx_pkt_arbiter_rr_pick2 u_pick (
        .req    ({src1_req, src0_req}),
        .last   (last_owner),
        .any    (pick_any),
        .winner (pick_winner)
    );

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            state      <= TXARB_IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            gnt        <= 2'b00;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            gnt        <= gnt_nxt;
        end
    end

    // Grant drops on the EOP edge, so IDLE always lasts one cycle before the next grant.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        gnt_nxt        = gnt;
        case (state)
            TXARB_IDLE: begin
                if (!pkt_tx_full && pick_any) begin
                    state_nxt = TXARB_BUSY;
                    owner_nxt = pick_winner;
                    gnt_nxt   = pick_winner ? 2'b10 : 2'b01;
                end
            end
            TXARB_BUSY: begin
                if (owner_eop) begin
                    state_nxt      = TXARB_IDLE;
                    gnt_nxt        = 2'b00;
                    last_owner_nxt = owner;
                end
            end
            default: begin
                state_nxt = TXARB_IDLE;
                gnt_nxt   = 2'b00;
            end
        endcase
    end

    assign src0_gnt  = gnt[0];
    assign src1_gnt  = gnt[1];
    assign dbg_state = state;

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            pkt_tx_val  <= 1'b0;
            pkt_tx_sop  <= 1'b0;
            pkt_tx_eop  <= 1'b0;
            pkt_tx_mod  <= 3'd0;
            pkt_tx_data <= 64'd0;
        end else if (owner_fire) begin
            pkt_tx_val  <= 1'b1;
            pkt_tx_sop  <= own_beat.sop;
            pkt_tx_eop  <= own_beat.eop;
            pkt_tx_mod  <= own_beat.eop ? own_beat.mod : 3'd0;
            pkt_tx_data <= own_beat.data;
        end else begin
            pkt_tx_val  <= 1'b0;
            pkt_tx_sop  <= 1'b0;
            pkt_tx_eop  <= 1'b0;
            pkt_tx_mod  <= 3'd0;
            pkt_tx_data <= 64'd0;
        end
    end

    // Any val without a grant is a stray beat; sop must mark exactly the first owner beat.
    assign stray_err = (src0_val && !gnt[0]) || (src1_val && !gnt[1]);
    assign sop_err   = owner_fire && (first_beat ? !own_beat.sop : own_beat.sop);

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            first_beat               <= 1'b0;
            beat_cnt                 <= '0;
            status_arb_proto_err_tog <= 1'b0;
            status_arb_oversize_tog  <= 1'b0;
            stat_src0_pkts           <= '0;
            stat_src1_pkts           <= '0;
        end else begin
            if (state == TXARB_IDLE) begin
                first_beat <= 1'b1;
            end else if (owner_fire) begin
                first_beat <= 1'b0;
            end

            if (state == TXARB_IDLE || owner_eop) begin
                beat_cnt <= '0;
            end else if (owner_fire && beat_cnt != MAX_CNT) begin
                beat_cnt <= beat_cnt + 1'b1;
            end

            if (stray_err || sop_err) begin
                status_arb_proto_err_tog <= ~status_arb_proto_err_tog;
            end

            if (owner_fire && !own_beat.eop && beat_cnt == LAST_CNT) begin
                status_arb_oversize_tog <= ~status_arb_oversize_tog;
            end

            if (owner_eop && !owner) begin
                stat_src0_pkts <= stat_src0_pkts + CNT_W'(1);
            end
            if (owner_eop && owner) begin
                stat_src1_pkts <= stat_src1_pkts + CNT_W'(1);
            end
        end
    end

endmodule
